// File: rtl/icache_refill_ctrl_if.sv
// AXI4 read address/read data channels between the icache refill controller (master) and memory (slave).
interface icache_refill_ctrl_if #(
  parameter int ADDR_W = 32
) ();
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              rvalid;
  logic              rready;
  logic [31:0]       rdata;
  logic              rlast;

  modport master (
    output arvalid, araddr, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rlast
  );

  modport slave (
    input  arvalid, araddr, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rlast
  );
endinterface

// File: rtl/icache_refill_ctrl.sv
// Icache refill: one AXI INCR burst per miss, beats streamed into the data RAM, tag written only after the last beat.
// Miss-to-done is LINE_WORDS+3 cycles minimum; stalls on arready/rvalid, and rready stays high for the whole burst.
module icache_refill_ctrl #(
  parameter int  SET_NUM    = 64,
  parameter int  LINE_WORDS = 8,
  parameter int  ADDR_W     = 32,
  localparam int IDX_W      = $clog2(SET_NUM),
  localparam int OFF_W      = $clog2(LINE_WORDS)
) (
  input  logic                   clka,
  input  logic                   rst_n,
  input  logic                   miss_req,
  input  logic [ADDR_W-1:0]      miss_addr,
  output logic                   busy,
  output logic                   refill_done,
  output logic                   err,
  icache_refill_ctrl_if.master   axi,
  output logic                   data_we,
  output logic [IDX_W+OFF_W-1:0] data_addr,
  output logic [31:0]            data_din,
  output logic                   tag_ena,
  output logic [3:0]             tag_wea,
  output logic [IDX_W-1:0]       tag_addra,
  output logic [31:0]            tag_dina
);
  localparam int               LINE_LSB  = OFF_W + 2;
  localparam int               TAG_LSB   = LINE_LSB + IDX_W;
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_TAG_WR, S_DONE} state_t;

  state_t                    state;
  logic [ADDR_W-1:LINE_LSB]  line_q;
  logic [OFF_W-1:0]          word_cnt;
  logic                      arvalid_q;
  logic [ADDR_W-1:0]         araddr_q;
  logic [7:0]                arlen_q;
  logic [2:0]                arsize_q;
  logic [1:0]                arburst_q;
  logic                      rready_q;
  logic [IDX_W-1:0]          index;
  logic                      beat;
  logic                      last_beat;
  logic                      unused_offset;

  assign index         = line_q[TAG_LSB-1:LINE_LSB];
  assign last_beat     = (word_cnt == LAST_WORD);
  assign unused_offset = ^miss_addr[LINE_LSB-1:0];

  // Beats go straight to the data RAM; gating with rst_n keeps the write port quiet during reset.
  assign beat      = rst_n && (state == S_R) && rready_q && axi.rvalid;
  assign data_we   = beat;
  assign data_addr = beat ? {index, word_cnt} : '0;
  assign data_din  = beat ? axi.rdata : '0;

  assign axi.arvalid = arvalid_q;
  assign axi.araddr  = araddr_q;
  assign axi.arlen   = arlen_q;
  assign axi.arsize  = arsize_q;
  assign axi.arburst = arburst_q;
  assign axi.rready  = rready_q;

  always_ff @(posedge clka) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      line_q      <= '0;
      word_cnt    <= '0;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      arsize_q    <= '0;
      arburst_q   <= '0;
      rready_q    <= 1'b0;
      busy        <= 1'b0;
      refill_done <= 1'b0;
      err         <= 1'b0;
      tag_ena     <= 1'b0;
      tag_wea     <= '0;
      tag_addra   <= '0;
      tag_dina    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (miss_req) begin
            line_q    <= miss_addr[ADDR_W-1:LINE_LSB];
            araddr_q  <= {miss_addr[ADDR_W-1:LINE_LSB], {LINE_LSB{1'b0}}};
            arlen_q   <= 8'(LINE_WORDS - 1);
            arsize_q  <= 3'b010;
            arburst_q <= 2'b01;
            arvalid_q <= 1'b1;
            busy      <= 1'b1;
            state     <= S_AR;
          end
        end
        S_AR: begin
          if (axi.arready) begin
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arsize_q  <= '0;
            arburst_q <= '0;
            rready_q  <= 1'b1;
            word_cnt  <= '0;
            state     <= S_R;
          end
        end
        S_R: begin
          if (beat) begin
            word_cnt <= word_cnt + 1'b1;
            // Line completion follows the beat count; a misplaced rlast only raises err.
            if (axi.rlast != last_beat) err <= 1'b1;
            if (last_beat) begin
              rready_q  <= 1'b0;
              tag_ena   <= 1'b1;
              tag_wea   <= 4'hF;
              tag_addra <= index;
              tag_dina  <= 32'(line_q[ADDR_W-1:TAG_LSB]);
              state     <= S_TAG_WR;
            end
          end
        end
        S_TAG_WR: begin
          tag_ena     <= 1'b0;
          tag_wea     <= '0;
          tag_addra   <= '0;
          tag_dina    <= '0;
          refill_done <= 1'b1;
          state       <= S_DONE;
        end
        S_DONE: begin
          refill_done <= 1'b0;
          busy        <= 1'b0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench: scripted AXI slave, a transaction-level model checked every cycle, plus literal pins per scenario.
`timescale 1ns/1ps
module tb_icache_refill_ctrl;
  logic        clka = 1'b0;
  always #5 clka = ~clka;

  logic        rst_n, miss_req;
  logic [31:0] miss_addr;
  logic        busy, refill_done, err, data_we, tag_ena;
  logic [8:0]  data_addr;
  logic [31:0] data_din, tag_dina;
  logic [3:0]  tag_wea;
  logic [5:0]  tag_addra;

  icache_refill_ctrl_if #(.ADDR_W(32)) axi ();

  icache_refill_ctrl dut (
    .clka(clka), .rst_n(rst_n), .miss_req(miss_req), .miss_addr(miss_addr),
    .busy(busy), .refill_done(refill_done), .err(err), .axi(axi),
    .data_we(data_we), .data_addr(data_addr), .data_din(data_din),
    .tag_ena(tag_ena), .tag_wea(tag_wea), .tag_addra(tag_addra), .tag_dina(tag_dina)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clka) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bound_chk(input string name, input int n, input int limit);
    checks++;
    if (n >= limit) begin
      errors++;
      $display("FAIL %s: waited %0d cycles, limit %0d", name, n, limit);
    end
  endtask

  // Slave configuration and state
  int         ar_stall, rv_len, rlast_at;
  logic [7:0] rv_pat;
  logic [31:0] dbase;
  int         s_beat, ar_cyc, pidx;
  bit         s_burst, hs_ar, hs_r, arv_seen;

  // Model state
  bit          live, rst_seen, m_active, m_ar_done, m_err;
  int          m_beats, m_tag_cyc, m_done_cyc, miss_cyc;
  logic [31:0] m_line;

  // Observation log
  int          wr_cnt, tag_cnt, done_cnt, ar_cycles, ar_start_cnt, ar_addr_changed;
  int          first_wr_cyc, last_wr_cyc, tag_cyc_seen, done_first, done_last, ar_start_cyc;
  logic [31:0] first_wa, first_wd, last_wa, last_wd, tag_a, tag_d, tag_we;
  logic [31:0] ar_addr_first, ar_addr_last, ar_len_last;
  bit          arv_prev;

  always @(negedge clka) begin : cmp
    bit          exp_ar, exp_rr, exp_we, exp_tag, exp_done;
    logic [5:0]  idx;
    logic [2:0]  w;
    logic [31:0] tagv;
    idx      = m_line[10:5];
    tagv     = {11'b0, m_line[31:11]};
    w        = m_beats[2:0];
    exp_ar   = m_active && !m_ar_done;
    exp_rr   = m_active && m_ar_done && (m_beats < 8);
    exp_we   = exp_rr && axi.rvalid && rst_n;
    exp_tag  = (cyc == m_tag_cyc);
    exp_done = (cyc == m_done_cyc);
    hs_ar    = axi.arvalid && axi.arready;
    hs_r     = axi.rvalid && axi.rready;
    arv_seen = axi.arvalid;

    if (live) begin
      chk("arvalid", axi.arvalid, exp_ar);
      if (exp_ar) begin
        chk("araddr", axi.araddr, m_line);
        chk("arlen", axi.arlen, 7);
        chk("arsize", axi.arsize, 2);
        chk("arburst", axi.arburst, 1);
      end
      chk("rready", axi.rready, exp_rr);
      chk("data_we", data_we, exp_we);
      if (exp_we) begin
        chk("data_addr", data_addr, {idx, w});
        chk("data_din", data_din, axi.rdata);
      end
      chk("tag_ena", tag_ena, exp_tag);
      chk("tag_wea", tag_wea, exp_tag ? 4'hF : 4'h0);
      if (exp_tag) begin
        chk("tag_addra", tag_addra, idx);
        chk("tag_dina", tag_dina, tagv);
      end
      chk("refill_done", refill_done, exp_done);
      chk("busy", busy, m_active);
      chk("err", err, m_err);
      if (rst_seen) begin
        chk("rst_araddr", axi.araddr, 0);
        chk("rst_arlen", axi.arlen, 0);
        chk("rst_arsize", axi.arsize, 0);
        chk("rst_arburst", axi.arburst, 0);
        chk("rst_data_addr", data_addr, 0);
        chk("rst_data_din", data_din, 0);
        chk("rst_tag_addra", tag_addra, 0);
        chk("rst_tag_dina", tag_dina, 0);
      end

      if (data_we) begin
        if (wr_cnt == 0) begin first_wa = data_addr; first_wd = data_din; first_wr_cyc = cyc; end
        last_wa = data_addr; last_wd = data_din; last_wr_cyc = cyc;
        wr_cnt++;
      end
      if (tag_ena) begin
        tag_cnt++; tag_a = tag_addra; tag_d = tag_dina; tag_we = tag_wea; tag_cyc_seen = cyc;
      end
      if (refill_done) begin
        if (done_cnt == 0) done_first = cyc;
        done_last = cyc;
        done_cnt++;
      end
      if (axi.arvalid) begin
        ar_cycles++;
        if (!arv_prev) begin
          ar_start_cnt++;
          if (ar_start_cnt == 1) ar_addr_first = axi.araddr;
          ar_addr_last = axi.araddr; ar_len_last = axi.arlen; ar_start_cyc = cyc;
        end else if (axi.araddr != ar_addr_last) ar_addr_changed++;
      end
    end
    arv_prev = axi.arvalid;

    // Advance the model across the edge that closes this cycle
    if (!rst_n) begin
      m_active = 0; m_ar_done = 0; m_beats = 0; m_err = 0;
      m_tag_cyc = -1; m_done_cyc = -1;
    end else if (!m_active) begin
      if (miss_req) begin
        m_active = 1; m_ar_done = 0; m_beats = 0;
        m_line = miss_addr & 32'hFFFF_FFE0; miss_cyc = cyc;
      end
    end else begin
      if (exp_ar && axi.arready) m_ar_done = 1;
      if (exp_rr && axi.rvalid) begin
        if (axi.rlast != (m_beats == 7)) m_err = 1;
        m_beats++;
        if (m_beats == 8) begin m_tag_cyc = cyc + 1; m_done_cyc = cyc + 2; end
      end
      if (exp_done) m_active = 0;
    end
    rst_seen = !rst_n;
    if (rst_seen) live = 1;
  end

  // Memory-side AXI responder
  initial begin
    axi.arready = 0; axi.rvalid = 0; axi.rdata = 0; axi.rlast = 0;
    forever begin
      @(posedge clka); #1;
      if (!rst_n) begin
        s_beat = 0; s_burst = 0; ar_cyc = 0; pidx = 0;
      end else begin
        if (hs_ar) begin s_burst = 1; s_beat = 0; pidx = 0; ar_cyc = 0; end
        else if (arv_seen) ar_cyc++;
        if (hs_r) begin s_beat++; if (s_beat == 8) s_burst = 0; end
      end
      axi.arready = (ar_cyc >= ar_stall);
      if (rst_n && s_burst && s_beat < 8) begin
        axi.rvalid = rv_pat[pidx % rv_len];
        pidx++;
      end else axi.rvalid = 0;
      axi.rdata = dbase + 32'(s_beat);
      axi.rlast = axi.rvalid && (s_beat == rlast_at);
    end
  end

  task automatic step();
    @(posedge clka); #2;
  endtask

  task automatic cfg(input int stall, input logic [7:0] pat, input int plen, input int rl, input logic [31:0] base);
    ar_stall = stall; rv_pat = pat; rv_len = plen; rlast_at = rl; dbase = base;
  endtask

  task automatic clear_log();
    wr_cnt = 0; tag_cnt = 0; done_cnt = 0; ar_cycles = 0; ar_start_cnt = 0; ar_addr_changed = 0;
  endtask

  task automatic wait_done(input int target, input string name);
    int n = 0;
    while (done_cnt < target && n < 300) begin step(); n++; end
    bound_chk(name, n, 300);
  endtask

  task automatic refill(input logic [31:0] a, input string name);
    miss_req = 1; miss_addr = a;
    step();
    miss_req = 0;
    wait_done(1, name);
  endtask

  initial begin
    int n;
    m_tag_cyc = -1; m_done_cyc = -1;
    rst_n = 0; miss_req = 0; miss_addr = 0;
    cfg(0, 8'h01, 1, 7, 32'hA0);
    clear_log();
    repeat (3) step();
    chk("reset_busy", busy, 0);
    chk("reset_arvalid", axi.arvalid, 0);
    chk("reset_err", err, 0);
    chk("reset_tag_ena", tag_ena, 0);
    rst_n = 1;
    step();

    // Basic refill
    clear_log();
    refill(32'h1FC0_0124, "basic_done");
    chk("basic_araddr", ar_addr_first, 32'h1FC0_0120);
    chk("basic_arlen", ar_len_last, 7);
    chk("basic_ar_cycles", ar_cycles, 1);
    chk("basic_first_wa", first_wa, 9'h048);
    chk("basic_first_wd", first_wd, 32'hA0);
    chk("basic_last_wa", last_wa, 9'h04F);
    chk("basic_last_wd", last_wd, 32'hA7);
    chk("basic_wr_cnt", wr_cnt, 8);
    chk("basic_tag_cnt", tag_cnt, 1);
    chk("basic_tag_addra", tag_a, 6'h09);
    chk("basic_tag_dina", tag_d, 32'h0003_F800);
    chk("basic_tag_wea", tag_we, 4'hF);
    chk("basic_latency", done_last - miss_cyc, 11);
    chk("basic_err", err, 0);

    // AR backpressure
    cfg(5, 8'h01, 1, 7, 32'hC0);
    clear_log();
    refill(32'h0000_1234, "arstall_done");
    chk("arstall_ar_cycles", ar_cycles, 6);
    chk("arstall_addr_stable", ar_addr_changed, 0);
    chk("arstall_first_beat", first_wr_cyc - ar_start_cyc, 6);
    chk("arstall_wr_cnt", wr_cnt, 8);
    chk("arstall_latency", done_last - miss_cyc, 16);

    // R gaps: rvalid 1,0,0 repeating
    cfg(0, 8'b0000_0001, 3, 7, 32'hD0);
    clear_log();
    refill(32'h8000_07E0, "rgap_done");
    chk("rgap_wr_cnt", wr_cnt, 8);
    chk("rgap_first_wa", first_wa, 9'h1F8);
    chk("rgap_last_wa", last_wa, 9'h1FF);
    chk("rgap_tag_after_last", tag_cyc_seen - last_wr_cyc, 1);
    chk("rgap_tag_dina", tag_d, 32'h0010_0000);
    chk("rgap_latency", done_last - miss_cyc, 25);

    // rlast early on beat 5, err sticky across a clean refill
    cfg(0, 8'h01, 1, 5, 32'h10);
    clear_log();
    refill(32'h0000_0000, "rlast5_done");
    chk("rlast5_err", err, 1);
    chk("rlast5_wr_cnt", wr_cnt, 8);
    chk("rlast5_tag_cnt", tag_cnt, 1);
    cfg(0, 8'h01, 1, 7, 32'h20);
    clear_log();
    refill(32'h0000_0020, "sticky_done");
    chk("sticky_err", err, 1);
    rst_n = 0;
    repeat (2) step();
    chk("rst_clears_err", err, 0);
    rst_n = 1;
    step();
    // rlast never asserted
    cfg(0, 8'h01, 1, 99, 32'h30);
    clear_log();
    refill(32'h0000_0060, "norlast_done");
    chk("norlast_err", err, 1);
    chk("norlast_wr_cnt", wr_cnt, 8);
    chk("norlast_tag_cnt", tag_cnt, 1);

    // Reset mid-burst
    cfg(0, 8'h01, 1, 7, 32'hB0);
    clear_log();
    miss_req = 1; miss_addr = 32'h1234_5660;
    step();
    miss_req = 0;
    n = 0;
    while (wr_cnt < 4 && n < 100) begin step(); n++; end
    bound_chk("midrst_beats", n, 100);
    rst_n = 0;
    repeat (3) step();
    chk("midrst_busy", busy, 0);
    chk("midrst_rready", axi.rready, 0);
    rst_n = 1;
    step();
    chk("midrst_no_tag", tag_cnt, 0);
    chk("midrst_no_done", done_cnt, 0);
    clear_log();
    refill(32'h0000_0040, "postrst_done");
    chk("postrst_tag_addra", tag_a, 6'h02);
    chk("postrst_tag_dina", tag_d, 0);
    chk("postrst_first_wa", first_wa, 9'h010);
    chk("postrst_wr_cnt", wr_cnt, 8);

    // Held miss_req across two refills, address changed mid-refill
    cfg(0, 8'h01, 1, 7, 32'hE0);
    clear_log();
    miss_req = 1; miss_addr = 32'h0000_0100;
    repeat (4) step();
    miss_addr = 32'h0000_0A40;
    n = 0;
    while (ar_start_cnt < 2 && n < 100) begin step(); n++; end
    bound_chk("held_second_ar", n, 100);
    miss_req = 0;
    wait_done(2, "held_done");
    chk("held_araddr1", ar_addr_first, 32'h0000_0100);
    chk("held_araddr2", ar_addr_last, 32'h0000_0A40);
    chk("held_gap", ar_start_cyc - done_first, 2);
    chk("held_tag_cnt", tag_cnt, 2);
    chk("held_wr_cnt", wr_cnt, 16);
    chk("held_tag_addra2", tag_a, 6'h12);

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded 1 ms without finishing");
    $fatal(1);
  end
endmodule

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
- Refill initiator for the instruction cache.
- On a miss it issues one AXI4 INCR burst read for the missing line and streams the returned beats into the data RAM.
- After the last data beat it writes the tag into port A of the tag RAM, then signals completion to the lookup stage.
- The tag is written only after all data, so a partially filled line is never visible as valid.

Parameters:
- SET_NUM, 64, number of sets; index width IDX_W = log2(SET_NUM) = 6.
- LINE_WORDS, 8, 32-bit words per line; offset word bits OFF_W = log2(LINE_WORDS) = 3.
- ADDR_W, 32, physical address width.

Ports:
- clka  in  1  clock.
- rst_n  in  1  reset.
- miss_req  in  1  miss request, level; sampled only in IDLE.
- miss_addr  in  32  missing address.
- busy  out  1  controller not in IDLE.
- refill_done  out  1  one-cycle completion pulse.
- err  out  1  sticky rlast/beat-count mismatch flag; cleared by reset only.
- arvalid  out  1  AXI AR valid.
- arready  in  1  AXI AR ready.
- araddr  out  32  burst start address.
- arlen  out  8  burst length.
- arsize  out  3  beat size.
- arburst  out  2  burst type.
- rvalid  in  1  AXI R valid.
- rready  out  1  AXI R ready.
- rdata  in  32  AXI R data.
- rlast  in  1  AXI R last.
- data_we  out  1  data RAM write strobe.
- data_addr  out  9  {index, word_cnt}.
- data_din  out  32  data RAM write data.
- tag_ena  out  1  tag RAM port A enable.
- tag_wea  out  4  tag RAM port A byte-write enable.
- tag_addra  out  6  tag RAM port A address (set index).
- tag_dina  out  32  tag RAM port A write data.

Behaviour:
- Reset: rst_n is synchronous, active-low, on clock clka. While low, state = IDLE and every output is 0, including err, word_cnt and the latched address.
- Reset mid-burst: the AXI transaction is abandoned with no tag write. System reset is global, so the slave is reset too.
- Address split:
  - offset = addr[4:0]
  - index = addr[10:5]
  - tag = addr[31:11]
  - Generalised: index = addr[OFF_W+2+IDX_W-1 : OFF_W+2].
- IDLE:
  - busy = 0.
  - If miss_req = 1 at a clock edge: latch line_addr = {miss_addr[31:5], 5'b0}, go to AR; busy = 1 from the next cycle.
- AR:
  - Drive arvalid = 1, araddr = line_addr, arlen = LINE_WORDS-1, arsize = 3'b010, arburst = 2'b01.
  - araddr and arlen are held stable until the handshake.
  - On arvalid & arready: go to R next cycle, word_cnt = 0.
  - arvalid never drops before arready.
- R:
  - rready = 1.
  - Each beat with rvalid & rready is written combinationally in the same cycle: data_we = 1, data_addr = {index, word_cnt}, data_din = rdata; word_cnt increments.
  - When the beat with word_cnt == LINE_WORDS-1 is accepted, go to TAG_WR.
  - If rlast != (word_cnt == LINE_WORDS-1) on any accepted beat, set err = 1. The state machine still follows the beat count.
  - Cycles with rvalid = 0 produce no write and no count change.
- TAG_WR (exactly one cycle):
  - tag_ena = 1, tag_wea = 4'hF, tag_addra = index.
  - tag_dina = {11'b0, line_addr[31:11]}.
  - rready = 0.
  - Next state: DONE.
- DONE (one cycle):
  - refill_done = 1, busy = 1.
  - Next state: IDLE.
  - The tag RAM write has committed at the end of TAG_WR. Its output is registered, so a lookup read addressed during DONE returns the new tag on the following cycle.
- Back-to-back misses: miss_req is ignored outside IDLE. A miss held high through DONE is accepted in the first IDLE cycle after DONE, giving 1 idle cycle between refills.
- Minimum refill latency, from the cycle miss_req is sampled to refill_done, with arready and rvalid always high: 1 (AR) + LINE_WORDS (R) + 1 (TAG_WR) + 1 (DONE) = 11 cycles.
- tag_ena, tag_wea and data_we are 0 in every state not listed above.

Test Plan:
- Basic refill:
  - Stimulus: miss_addr = 0x1FC0_0124 with arready = 1; rvalid every cycle, rdata = 0xA0..0xA7, rlast on beat 7.
  - Required: araddr = 0x1FC0_0120, arlen = 7; data_addr = 0x048..0x04F carrying 0xA0..0xA7.
  - Then exactly one tag write: tag_addra = 0x09, tag_dina = 0x0003_F800, tag_wea = 0xF.
  - refill_done pulses at cycle 11; err = 0.
- AR backpressure: arready held 0 for 5 cycles.
  - Required: arvalid and araddr stable throughout; no data_we until after the handshake.
- R gaps: rvalid toggled 1,0,0,1,...
  - Required: exactly 8 data_we pulses with word_cnt contiguous 0..7; tag write only after the 8th beat.
- rlast anomalies: rlast on beat 5, then separately missing on beat 7.
  - Required: err = 1 and sticky; still 8 data writes and 1 tag write.
- Reset mid-burst: rst_n = 0 after beat 3, then miss at 0x0000_0040.
  - Required: all outputs 0 during reset; no tag write for the aborted line.
  - New refill proceeds normally with tag_addra = 0x02, tag_dina = 0.
- Held miss_req: miss_req held 1 through two refills with the address changed mid-refill.
  - Required: the second araddr reflects miss_addr sampled in the IDLE cycle after DONE; one idle cycle between refill_done and the second arvalid.
